alu_serial_seq: RTL and testbench

//  Bit-serial sequencer wrapped around one 1-bit ALU slice. Latches two 24-bit

---
 rtl/alu_serial_seq.sv | 183 ++++++++++++++++++
 tb/tb_alu_serial_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer driving an external 1-bit ALU slice LSB-first.
// The slice carry-out is fed back as the next bit's carry-in; SLT takes one extra fix-up cycle.
module alu_serial_seq #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       alu_ctl,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_ainv,
  output logic             slice_binv,
  output logic             slice_cin,
  output logic             slice_less,
  output logic [3:0]       slice_op,
  input  logic             slice_result,
  input  logic             slice_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [1:0]    OP_ADD   = 2'b10;
  localparam logic [1:0]    OP_SLT   = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    SLT_FIX = 2'b10,
    DONE    = 2'b11
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  // Shift registers hold only the bits not yet presented to the slice.
  logic [WIDTH-2:0] a_sh_r;
  logic [WIDTH-2:0] b_sh_r;
  logic [WIDTH-2:0] result_sh_r;
  logic             a0_r;
  logic             b0_r;
  logic [1:0]       op_r;
  logic             carry_r;
  logic             ovf_r;

  logic [WIDTH-1:0] final_s;
  logic             msb_ovf_s;
  logic             last_s;

  assign final_s   = {slice_result, result_sh_r};
  assign msb_ovf_s = slice_cin ^ slice_cout;
  assign last_s    = (cnt_r == CNT_LAST);

  // Sequencer: accept, bit-serial run, SLT fix-up, one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      a_sh_r      <= {(WIDTH-1){1'b0}};
      b_sh_r      <= {(WIDTH-1){1'b0}};
      result_sh_r <= {(WIDTH-1){1'b0}};
      a0_r        <= 1'b0;
      b0_r        <= 1'b0;
      op_r        <= 2'b00;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      slice_a     <= 1'b0;
      slice_b     <= 1'b0;
      slice_ainv  <= 1'b0;
      slice_binv  <= 1'b0;
      slice_cin   <= 1'b0;
      slice_less  <= 1'b0;
      slice_op    <= 4'b0000;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= {WIDTH{1'b0}};
      zero        <= 1'b0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r     <= RUN;
            busy        <= 1'b1;
            cnt_r       <= {CW{1'b0}};
            a_sh_r      <= op_a[WIDTH-1:1];
            b_sh_r      <= op_b[WIDTH-1:1];
            result_sh_r <= {(WIDTH-1){1'b0}};
            a0_r        <= op_a[0];
            b0_r        <= op_b[0];
            op_r        <= alu_ctl[1:0];
            carry_r     <= 1'b0;
            ovf_r       <= 1'b0;
            slice_a     <= op_a[0];
            slice_b     <= op_b[0];
            slice_ainv  <= alu_ctl[3];
            slice_binv  <= alu_ctl[2];
            slice_cin   <= alu_ctl[2];
            slice_less  <= 1'b0;
            // SLT runs the A-B pass through the adder, the less mux comes later.
            slice_op    <= {1'b0, ((alu_ctl[1:0] == OP_SLT) ? OP_ADD : alu_ctl[1:0]), alu_ctl[2]};
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          result_sh_r <= {slice_result, result_sh_r[WIDTH-2:1]};
          a_sh_r      <= {1'b0, a_sh_r[WIDTH-2:1]};
          b_sh_r      <= {1'b0, b_sh_r[WIDTH-2:1]};
          cnt_r       <= cnt_r + CW'(1);
          slice_a     <= a_sh_r[0];
          slice_b     <= b_sh_r[0];
          slice_cin   <= slice_cout;
          if (last_s) begin
            if (op_r == OP_SLT) begin
              state_r    <= SLT_FIX;
              carry_r    <= slice_cout;
              ovf_r      <= msb_ovf_s;
              slice_a    <= a0_r;
              slice_b    <= b0_r;
              slice_cin  <= 1'b0;
              // Sign of A-B corrected for overflow.
              slice_less <= slice_result ^ msb_ovf_s;
              slice_op   <= {1'b0, OP_SLT, slice_binv};
            end else begin
              state_r    <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              result     <= final_s;
              zero       <= (final_s == {WIDTH{1'b0}});
              carry      <= (op_r == OP_ADD) ? slice_cout : 1'b0;
              overflow   <= (op_r == OP_ADD) ? msb_ovf_s : 1'b0;
              slice_a    <= 1'b0;
              slice_b    <= 1'b0;
              slice_ainv <= 1'b0;
              slice_binv <= 1'b0;
              slice_cin  <= 1'b0;
              slice_less <= 1'b0;
              slice_op   <= 4'b0000;
            end
          end else begin
            state_r <= RUN;
          end
        end
        SLT_FIX: begin
          state_r    <= DONE;
          busy       <= 1'b0;
          done       <= 1'b1;
          result     <= {{(WIDTH-1){1'b0}}, slice_result};
          zero       <= ~slice_result;
          carry      <= carry_r;
          overflow   <= ovf_r;
          slice_a    <= 1'b0;
          slice_b    <= 1'b0;
          slice_ainv <= 1'b0;
          slice_binv <= 1'b0;
          slice_cin  <= 1'b0;
          slice_less <= 1'b0;
          slice_op   <= 4'b0000;
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq with a behavioural 1-bit ALU slice and an
// arithmetic scoreboard of expected results.
module tb_alu_serial_seq;

  localparam int W = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [3:0]    alu_ctl;
  logic          slice_a, slice_b, slice_ainv, slice_binv, slice_cin, slice_less;
  logic [3:0]    slice_op;
  logic          slice_result, slice_cout;
  logic          busy, done, zero, carry, overflow;
  logic [W-1:0]  result;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
    logic [7:0]   lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .alu_ctl(alu_ctl),
    .slice_a(slice_a), .slice_b(slice_b), .slice_ainv(slice_ainv), .slice_binv(slice_binv),
    .slice_cin(slice_cin), .slice_less(slice_less), .slice_op(slice_op),
    .slice_result(slice_result), .slice_cout(slice_cout),
    .busy(busy), .done(done), .result(result), .zero(zero), .carry(carry), .overflow(overflow)
  );

  // Classic 1-bit ALU slice: inverters, AND/OR/full adder/LESS mux.
  logic sa_s, sb_s;
  always_comb begin
    sa_s       = slice_a ^ slice_ainv;
    sb_s       = slice_b ^ slice_binv;
    slice_cout = (sa_s & sb_s) | (sa_s & slice_cin) | (sb_s & slice_cin);
    case (slice_op[2:1])
      2'b00:   slice_result = sa_s & sb_s;
      2'b01:   slice_result = sa_s | sb_s;
      2'b10:   slice_result = sa_s ^ sb_s ^ slice_cin;
      default: slice_result = slice_less;
    endcase
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] ctl);
    logic [W-1:0] aa, bb;
    logic [W:0]   s;
    logic         v;
    exp_t         e;
    aa    = ctl[3] ? ~a : a;
    bb    = ctl[2] ? ~b : b;
    s     = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ctl[2]};
    v     = (aa[W-1] == bb[W-1]) && (s[W-1] != aa[W-1]);
    e.c   = 1'b0;
    e.v   = 1'b0;
    e.lat = 8'd25;
    case (ctl[1:0])
      2'b00:   e.res = aa & bb;
      2'b01:   e.res = aa | bb;
      2'b10:   begin e.res = s[W-1:0]; e.c = s[W]; e.v = v; end
      default: begin e.res = {{(W-1){1'b0}}, s[W-1] ^ v}; e.c = s[W]; e.v = v; e.lat = 8'd26; end
    endcase
    e.z = (e.res == {W{1'b0}});
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; alu_ctl = 4'b0000;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, zero, carry, overflow} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, zero, carry, overflow});
    end
    n_tests++;
    if (result !== {W{1'b0}}) begin
      n_fail++; $display("FAIL reset_result: got %h expected 000000", result);
    end
    n_tests++;
    if ({slice_a, slice_b, slice_ainv, slice_binv, slice_cin, slice_less, slice_op} !== 10'b0) begin
      n_fail++; $display("FAIL reset_slice: got %b expected all zero",
                         {slice_a, slice_b, slice_ainv, slice_binv, slice_cin, slice_less, slice_op});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ops();
    logic [W-1:0] va[$];
    logic [W-1:0] vb[$];
    logic [3:0]   vc[$];
    logic [3:0]   c;
    exp_t         e;
    int           cyc;
    va.push_back(24'h000001); vb.push_back(24'hFFFFFF); vc.push_back(4'b0010); // ADD wrap
    va.push_back(24'h000005); vb.push_back(24'h000007); vc.push_back(4'b0110); // 5-7
    va.push_back(24'h000007); vb.push_back(24'h000005); vc.push_back(4'b0110); // 7-5
    va.push_back(24'hFFFFFB); vb.push_back(24'h000003); vc.push_back(4'b0111); // SLT -5,3
    va.push_back(24'h000003); vb.push_back(24'hFFFFFB); vc.push_back(4'b0111); // SLT 3,-5
    va.push_back(24'h7FFFFF); vb.push_back(24'h000001); vc.push_back(4'b0010); // overflow
    va.push_back(24'hF0F0F0); vb.push_back(24'h0FF0FF); vc.push_back(4'b0000); // AND
    va.push_back(24'h000000); vb.push_back(24'h000000); vc.push_back(4'b1100); // NOR
    va.push_back(24'hA50000); vb.push_back(24'h00005A); vc.push_back(4'b0001); // OR
    va.push_back(24'hFF00FF); vb.push_back(24'h0F0F0F); vc.push_back(4'b1101); // NAND
    for (int r = 0; r < 6; r++) begin
      c = 4'($urandom_range(0, 15));
      if (c[1:0] == 2'b11) c[1:0] = 2'b10;
      va.push_back(W'($urandom)); vb.push_back(W'($urandom)); vc.push_back(c);
    end
    foreach (va[i]) begin
      @(negedge clk);
      op_a = va[i]; op_b = vb[i]; alu_ctl = vc[i]; start = 1'b1;
      sb_q.push_back(model(va[i], vb[i], vc[i]));
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 40) begin @(negedge clk); cyc++; end
      e = sb_q.pop_front();
      n_tests++;
      if (done !== 1'b1 || cyc != int'(e.lat)) begin
        n_fail++; $display("FAIL op%0d_latency: got done=%b at cycle %0d expected cycle %0d", i, done, cyc, e.lat);
      end
      n_tests++;
      if (result !== e.res) begin
        n_fail++; $display("FAIL op%0d_result: got %h expected %h (a=%h b=%h ctl=%b)", i, result, e.res, va[i], vb[i], vc[i]);
      end
      n_tests++;
      if ({zero, carry, overflow} !== {e.z, e.c, e.v}) begin
        n_fail++; $display("FAIL op%0d_flags: got zcv=%b expected %b", i, {zero, carry, overflow}, {e.z, e.c, e.v});
      end
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL op%0d_busy_at_done: got %b expected 0", i, busy);
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || result !== e.res) begin
        n_fail++; $display("FAIL op%0d_hold: got done=%b result=%h expected done=0 result=%h", i, done, result, e.res);
      end
    end
  endtask

  task automatic test_ignored_start();
    exp_t e;
    int   cyc, extra;
    @(negedge clk);
    op_a = 24'h123456; op_b = 24'h111111; alu_ctl = 4'b0010; start = 1'b1;
    sb_q.push_back(model(24'h123456, 24'h111111, 4'b0010));
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk); cyc++;
      if (cyc == 5) begin
        start = 1'b1; op_a = 24'hFFFFFF; op_b = 24'hFFFFFF; alu_ctl = 4'b0001;
      end else begin
        start = 1'b0;
      end
    end
    e = sb_q.pop_front();
    n_tests++;
    if (done !== 1'b1 || cyc != 25) begin
      n_fail++; $display("FAIL ignored_latency: got done=%b at cycle %0d expected cycle 25", done, cyc);
    end
    n_tests++;
    if (result !== e.res) begin
      n_fail++; $display("FAIL ignored_result: got %h expected %h", result, e.res);
    end
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_tests++;
    if (extra != 0) begin
      n_fail++; $display("FAIL ignored_no_second_op: got %0d active cycles expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    @(negedge clk);
    op_a = 24'd10; op_b = 24'd20; alu_ctl = 4'b0010; start = 1'b1;
    sb_q.push_back(model(24'd10, 24'd20, 4'b0010));
    cyc = 0;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    e = sb_q.pop_front();
    n_tests++;
    if (done !== 1'b1 || result !== e.res) begin
      n_fail++; $display("FAIL b2b_first: got done=%b result=%h expected done=1 result=%h", done, result, e.res);
    end
    op_a = 24'd100;
    sb_q.push_back(model(24'd100, 24'd20, 4'b0010));
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 60) begin @(negedge clk); cyc++; end
    start = 1'b0;
    e = sb_q.pop_front();
    n_tests++;
    if (done !== 1'b1 || cyc != 26) begin
      n_fail++; $display("FAIL b2b_interval: got done=%b after %0d cycles expected 26", done, cyc);
    end
    n_tests++;
    if (result !== e.res) begin
      n_fail++; $display("FAIL b2b_second_result: got %h expected %h", result, e.res);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_stop: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   cyc, seen;
    @(negedge clk);
    op_a = 24'h00ABCD; op_b = 24'h001111; alu_ctl = 4'b0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 11) begin @(negedge clk); cyc++; end
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, zero, carry, overflow} !== 5'b00000 || result !== {W{1'b0}} || slice_op !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_clear: got flags=%b result=%h slice_op=%b expected all zero",
                         {busy, done, zero, carry, overflow}, result, slice_op);
    end
    seen = 0;
    repeat (3) begin @(negedge clk); if (done === 1'b1) seen++; end
    rst_n = 1'b1;
    repeat (30) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) seen++; end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", seen);
    end
    @(negedge clk);
    op_a = 24'h400000; op_b = 24'h0000FF; alu_ctl = 4'b0001; start = 1'b1;
    sb_q.push_back(model(24'h400000, 24'h0000FF, 4'b0001));
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    e = sb_q.pop_front();
    n_tests++;
    if (done !== 1'b1 || cyc != 25 || result !== e.res) begin
      n_fail++; $display("FAIL midrst_recover: got done=%b cycle=%0d result=%h expected cycle 25 result %h",
                         done, cyc, result, e.res);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ops();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
